// File: rtl/inst_trace_buffer.sv
// inst_trace_buffer: captures one {pc, inst} record per retired instruction
// into a first-word-fall-through FIFO drained through a valid/ready port.
// Retirements are counted, and records arriving while the FIFO is full are
// dropped and counted.
module inst_trace_buffer #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned AF_LEVEL = 12
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     commit,
   input  logic [ADDR_W-1:0]        pc,
   input  logic [DATA_W-1:0]        inst,
   input  logic                     clr,
   input  logic                     rd_ready,
   output logic                     rd_valid,
   output logic [ADDR_W-1:0]        rd_pc,
   output logic [DATA_W-1:0]        rd_inst,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     almost_full,
   output logic                     overflow,
   output logic [15:0]              drop_cnt,
   output logic [31:0]              retired_cnt
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned PTR_W = AW + 1;
   localparam int unsigned DCN_W = 16;
   localparam int unsigned RET_W = 32;

   // Elaboration-time parameter sanity
   generate
      if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
         $error("inst_trace_buffer: DEPTH must be a power of two >= 2");
      end
      if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
         $error("inst_trace_buffer: AF_LEVEL must be within 1..DEPTH");
      end
   endgenerate

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] inst;
   } trace_rec_t;

   trace_rec_t              mem_q [DEPTH];
   trace_rec_t              head_c;
   trace_rec_t              wr_rec_c;

   logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
   logic                    overflow_q, overflow_d;
   logic [DCN_W-1:0]        drop_cnt_q, drop_cnt_d;
   logic [RET_W-1:0]        retired_cnt_q, retired_cnt_d;

   logic [PTR_W-1:0]        level_c;
   logic                    empty_c;
   logic                    full_c;
   logic                    pop_c;
   logic                    push_c;
   logic                    drop_c;
   logic                    mem_we_c;

   // Occupancy and handshake decode; the extra pointer MSB separates full from empty
   always_comb begin
      level_c  = wr_ptr_q - rd_ptr_q;
      empty_c  = (level_c == '0);
      full_c   = (level_c == PTR_W'(DEPTH));
      pop_c    = !empty_c && rd_ready;
      push_c   = commit && (!full_c || pop_c);
      drop_c   = commit && full_c && !pop_c;
      mem_we_c = push_c && !clr;
      wr_rec_c = '{pc: pc, inst: inst};
   end

   // Head record presentation; forced to zero while empty so reset reads zero
   always_comb begin
      head_c      = mem_q[rd_ptr_q[AW-1:0]];
      rd_valid    = !empty_c;
      almost_full = (level_c >= PTR_W'(AF_LEVEL));
      level       = level_c;
      rd_pc       = empty_c ? '0 : head_c.pc;
      rd_inst     = empty_c ? '0 : head_c.inst;
      overflow    = overflow_q;
      drop_cnt    = drop_cnt_q;
      retired_cnt = retired_cnt_q;
   end

   // Next-state for pointers, sticky overflow and counters; clr wins over everything
   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      overflow_d    = overflow_q;
      drop_cnt_d    = drop_cnt_q;
      retired_cnt_d = retired_cnt_q;

      if (clr) begin
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         overflow_d    = 1'b0;
         drop_cnt_d    = '0;
         retired_cnt_d = '0;
      end else begin
         if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (commit) begin
            retired_cnt_d = retired_cnt_q + RET_W'(1);
         end
         if (drop_c) begin
            overflow_d = 1'b1;
            if (drop_cnt_q != '1) begin
               drop_cnt_d = drop_cnt_q + DCN_W'(1);
            end
         end
      end
   end

   // Control state registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         overflow_q    <= 1'b0;
         drop_cnt_q    <= '0;
         retired_cnt_q <= '0;
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         overflow_q    <= overflow_d;
         drop_cnt_q    <= drop_cnt_d;
         retired_cnt_q <= retired_cnt_d;
      end
   end

   // Record storage; contents are never shown while empty, so no reset needed
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_rec_c;
      end
   end

endmodule
